if_stage_fetch: RTL and testbench

- Instruction-fetch stage that sits directly upstream of Instruction_Memory.
- Owns the program counter and drives it to the instruction memory, whose read is combinational.
- Captures the returned word, with its PC, into an IF/ID register for decode.
- Handles pipeline stall, branch/jump redirect with flush, halt detection, and fetch-fault trapping.

---
 rtl/if_stage_fetch.sv | 106 ++++++++++
 tb/tb_if_stage_fetch.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/if_stage_fetch.sv
// Instruction-fetch stage: owns the PC, feeds a combinational instruction memory
// and captures the returned word with its PC into the IF/ID register.
module if_stage_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 128,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013,
  parameter logic [31:0] HALT_INSTR = 32'h0000_0073
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic [31:0] instr_in,
  output logic [31:0] pc_out,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        halted,
  output logic        misaligned,
  output logic        out_of_range
);

  typedef enum logic [1:0] {RUN, HALTED, FAULT} state_t;

  localparam logic [31:0] PC_LIMIT = 32'(IMEM_WORDS) << 2;

  state_t      state, state_next;
  logic [31:0] pc_next, instr_next, ipc_next, ipc4_next;
  logic        valid_next, misaligned_next, oor_next;

  always_comb begin
    state_next      = state;
    pc_next         = pc_out;
    instr_next      = ifid_instr;
    ipc_next        = ifid_pc;
    ipc4_next       = ifid_pc_plus4;
    valid_next      = ifid_valid;
    misaligned_next = misaligned;
    oor_next        = out_of_range;
    case (state)
      RUN: begin
        // Redirect wins over stall; the wrong-path word in instr_in is dropped unchecked.
        if (redirect_valid) begin
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
          if (redirect_target[1:0] != 2'b00) begin
            misaligned_next = 1'b1;
            state_next      = FAULT;
          end else begin
            pc_next = redirect_target;
          end
        end else if (stall) begin
          state_next = RUN;
        end else if (pc_out >= PC_LIMIT) begin
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
          oor_next   = 1'b1;
          state_next = FAULT;
        end else begin
          instr_next = instr_in;
          ipc_next   = pc_out;
          ipc4_next  = pc_out + 32'd4;
          valid_next = 1'b1;
          if (instr_in == HALT_INSTR) state_next = HALTED;
          else                        pc_next    = pc_out + 32'd4;
        end
      end
      HALTED: begin
        // Halt word stays visible for one cycle, then the register drains to a bubble.
        if (!stall) begin
          instr_next = NOP_INSTR;
          valid_next = 1'b0;
        end
      end
      FAULT:   valid_next = 1'b0;
      default: state_next = FAULT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= RUN;
      pc_out        <= RESET_PC;
      ifid_instr    <= NOP_INSTR;
      ifid_pc       <= 32'h0;
      ifid_pc_plus4 <= 32'h0;
      ifid_valid    <= 1'b0;
      misaligned    <= 1'b0;
      out_of_range  <= 1'b0;
    end else begin
      state         <= state_next;
      pc_out        <= pc_next;
      ifid_instr    <= instr_next;
      ifid_pc       <= ipc_next;
      ifid_pc_plus4 <= ipc4_next;
      ifid_valid    <= valid_next;
      misaligned    <= misaligned_next;
      out_of_range  <= oor_next;
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: tb/tb_if_stage_fetch.sv
// Directed bench for if_stage_fetch: a default-depth instance plus a 4-word
// instance for the out-of-range trap, each fed by a combinational memory model.
module tb_if_stage_fetch;

  logic        clk = 1'b0;
  logic        reset, stall, redirect_valid;
  logic [31:0] redirect_target;

  logic [31:0] instr_in, pc_out, ifid_instr, ifid_pc, ifid_pc_plus4;
  logic        ifid_valid, halted, misaligned, out_of_range;

  logic [31:0] instr_in2, pc_out2, ifid_instr2, ifid_pc2, ifid_pc_plus42;
  logic        ifid_valid2, halted2, misaligned2, out_of_range2;

  logic [31:0] mem  [64];
  logic [31:0] mem2 [4];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign instr_in  = (pc_out  < 32'd256) ? mem[pc_out[7:2]]   : 32'h0;
  assign instr_in2 = (pc_out2 < 32'd16)  ? mem2[pc_out2[3:2]] : 32'h0;

  if_stage_fetch dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .instr_in(instr_in), .pc_out(pc_out),
    .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc_plus4(ifid_pc_plus4),
    .ifid_valid(ifid_valid), .halted(halted), .misaligned(misaligned),
    .out_of_range(out_of_range)
  );

  if_stage_fetch #(.IMEM_WORDS(4)) dut_small (
    .clk(clk), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .instr_in(instr_in2), .pc_out(pc_out2),
    .ifid_instr(ifid_instr2), .ifid_pc(ifid_pc2), .ifid_pc_plus4(ifid_pc_plus42),
    .ifid_valid(ifid_valid2), .halted(halted2), .misaligned(misaligned2),
    .out_of_range(out_of_range2)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    vectors++; if (pc_out !== 32'h0) begin miscompares++; $display("FAIL reset_pc got %h want %h", pc_out, 32'h0); end
    vectors++; if (ifid_instr !== 32'h13) begin miscompares++; $display("FAIL reset_instr got %h want %h", ifid_instr, 32'h13); end
    vectors++; if (ifid_pc !== 32'h0 || ifid_pc_plus4 !== 32'h0) begin miscompares++; $display("FAIL reset_ifid_pc got %h/%h want 0/0", ifid_pc, ifid_pc_plus4); end
    vectors++; if ({ifid_valid, halted, misaligned, out_of_range} !== 4'b0000) begin miscompares++; $display("FAIL reset_flags got %b want 0000", {ifid_valid, halted, misaligned, out_of_range}); end
    vectors++; if (pc_out2 !== 32'h0 || ifid_valid2 !== 1'b0) begin miscompares++; $display("FAIL reset_small got pc=%h v=%b want 0/0", pc_out2, ifid_valid2); end
    reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_instr [3];
    exp_instr[0] = 32'h11; exp_instr[1] = 32'h22; exp_instr[2] = 32'h33;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (ifid_pc !== 32'(4*i) || ifid_instr !== exp_instr[i] || ifid_valid !== 1'b1) begin
        miscompares++; $display("FAIL seq_capture%0d got %h/%h v=%b want %h/%h v=1", i, ifid_pc, ifid_instr, ifid_valid, 4*i, exp_instr[i]);
      end
    end
    vectors++; if (pc_out !== 32'd12) begin miscompares++; $display("FAIL seq_pc got %h want %h", pc_out, 32'd12); end
    vectors++; if (ifid_pc_plus4 !== 32'd12) begin miscompares++; $display("FAIL seq_plus4 got %h want %h", ifid_pc_plus4, 32'd12); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++; if (pc_out !== 32'd8 || ifid_pc !== 32'd4 || ifid_instr !== 32'h22 || ifid_valid !== 1'b1) begin
        miscompares++; $display("FAIL stall_hold%0d got pc=%h ifid=%h/%h v=%b want 8, 4/22 v=1", i, pc_out, ifid_pc, ifid_instr, ifid_valid);
      end
    end
    stall = 1'b0;
    tick();
    vectors++; if (ifid_pc !== 32'd8 || ifid_instr !== 32'h33 || pc_out !== 32'd12) begin
      miscompares++; $display("FAIL stall_release got pc=%h ifid=%h/%h want c, 8/33", pc_out, ifid_pc, ifid_instr);
    end
  endtask

  task automatic test_redirect();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    vectors++; if (pc_out !== 32'h10) begin miscompares++; $display("FAIL redir_setup got %h want %h", pc_out, 32'h10); end
    stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    vectors++; if (pc_out !== 32'h40 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13) begin
      miscompares++; $display("FAIL redir_flush got pc=%h v=%b instr=%h want 40, 0, 13", pc_out, ifid_valid, ifid_instr);
    end
    tick();
    vectors++; if (ifid_pc !== 32'h40 || ifid_instr !== 32'hAA || ifid_valid !== 1'b1 || pc_out !== 32'h44) begin
      miscompares++; $display("FAIL redir_target got ifid=%h/%h v=%b pc=%h want 40/aa v=1 pc=44", ifid_pc, ifid_instr, ifid_valid, pc_out);
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    tick();
    redirect_valid = 1'b1; redirect_target = 32'h42;
    tick();
    vectors++; if (misaligned !== 1'b1 || pc_out !== 32'h4 || ifid_valid !== 1'b0 || ifid_instr !== 32'h13) begin
      miscompares++; $display("FAIL misalign_trap got mis=%b pc=%h v=%b instr=%h want 1, 4, 0, 13", misaligned, pc_out, ifid_valid, ifid_instr);
    end
    redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    tick();
    vectors++; if (pc_out !== 32'h4 || ifid_valid !== 1'b0 || misaligned !== 1'b1 || halted !== 1'b0) begin
      miscompares++; $display("FAIL misalign_frozen got pc=%h v=%b mis=%b h=%b want 4, 0, 1, 0", pc_out, ifid_valid, misaligned, halted);
    end
    do_reset();
    vectors++; if (pc_out !== 32'h0 || misaligned !== 1'b0 || out_of_range !== 1'b0) begin
      miscompares++; $display("FAIL misalign_reset got pc=%h mis=%b oor=%b want 0,0,0", pc_out, misaligned, out_of_range);
    end
    tick();
    vectors++; if (ifid_instr !== 32'h11 || ifid_valid !== 1'b1) begin
      miscompares++; $display("FAIL misalign_resume got %h v=%b want 11 v=1", ifid_instr, ifid_valid);
    end
  endtask

  task automatic test_halt();
    mem[2] = 32'h73;
    do_reset();
    tick(); tick(); tick();
    vectors++; if (ifid_pc !== 32'h8 || ifid_instr !== 32'h73 || ifid_valid !== 1'b1 || halted !== 1'b1 || pc_out !== 32'h8) begin
      miscompares++; $display("FAIL halt_capture got ifid=%h/%h v=%b h=%b pc=%h want 8/73 v=1 h=1 pc=8", ifid_pc, ifid_instr, ifid_valid, halted, pc_out);
    end
    redirect_valid = 1'b1; redirect_target = 32'h40;
    tick();
    redirect_valid = 1'b0;
    vectors++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h13 || pc_out !== 32'h8 || halted !== 1'b1) begin
      miscompares++; $display("FAIL halt_drain got v=%b instr=%h pc=%h h=%b want 0, 13, 8, 1", ifid_valid, ifid_instr, pc_out, halted);
    end
    mem[2] = 32'h33;
    do_reset();
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_reset got %b want 0", halted); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    for (int i = 0; i < 4; i++) tick();
    vectors++; if (ifid_pc2 !== 32'hC || ifid_instr2 !== 32'hA3 || pc_out2 !== 32'h10 || ifid_valid2 !== 1'b1) begin
      miscompares++; $display("FAIL oor_last got ifid=%h/%h pc=%h v=%b want c/a3 pc=10 v=1", ifid_pc2, ifid_instr2, pc_out2, ifid_valid2);
    end
    tick();
    vectors++; if (out_of_range2 !== 1'b1 || ifid_valid2 !== 1'b0 || pc_out2 !== 32'h10 || ifid_instr2 !== 32'h13) begin
      miscompares++; $display("FAIL oor_trap got oor=%b v=%b pc=%h instr=%h want 1, 0, 10, 13", out_of_range2, ifid_valid2, pc_out2, ifid_instr2);
    end
    tick();
    vectors++; if (out_of_range2 !== 1'b1 || pc_out2 !== 32'h10 || misaligned2 !== 1'b0) begin
      miscompares++; $display("FAIL oor_sticky got oor=%b pc=%h mis=%b want 1, 10, 0", out_of_range2, pc_out2, misaligned2);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h13;
    mem[0] = 32'h11; mem[1] = 32'h22; mem[2] = 32'h33; mem[3] = 32'h44;
    mem[16] = 32'hAA;
    mem2[0] = 32'hA0; mem2[1] = 32'hA1; mem2[2] = 32'hA2; mem2[3] = 32'hA3;
    reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_misaligned();
    test_halt();
    test_out_of_range();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
